// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO on the core's data-memory port.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      BASE     = 'hFFFF_FF00,
  parameter int unsigned           CLKDIV   = 434,
  parameter int unsigned           FIFOBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             memwrite,
  output logic             sel,
  output logic [WIDTH-1:0] rdata,
  output logic             txd
);

  localparam int unsigned   DEPTH  = 1 << FIFOBITS;
  localparam int unsigned   CW     = $clog2(CLKDIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]          mem [DEPTH];
  logic [FIFOBITS-1:0] wptr, rptr;
  logic [FIFOBITS:0]   count;
  logic                overflow;
  logic                full, empty, wr_tx, wr_st, push, pop;
  logic [7:0]          head;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [7:0]          shift, shift_nx;
  logic [2:0]          bitn, bitn_nx;
  logic                txd_nx;
`ifdef MMIO_UART_TX_PARITY_EN
  logic                parity, parity_nx;
`endif

  logic [WIDTH-1:0]    status;
  logic                unused;

  assign unused = ^{addr[1:0], wdata[WIDTH-1:8]};

  assign sel   = (addr[WIDTH-1:4] == BASE[WIDTH-1:4]);
  assign wr_tx = sel & memwrite & (addr[3:2] == 2'd0);
  assign wr_st = sel & memwrite & (addr[3:2] == 2'd1);
  assign full  = (count == (FIFOBITS+1)'(DEPTH));
  assign empty = (count == '0);
  // Full is judged before this cycle's pop, so a push into a full FIFO is always dropped.
  assign push  = wr_tx & ~full;
  assign head  = mem[rptr];

  always_comb begin
    status                 = '0;
    status[8 +: FIFOBITS+1] = count;
    status[3]              = overflow;
    status[2]              = (state != S_IDLE);
    status[1]              = empty;
    status[0]              = full;
`ifdef MMIO_UART_TX_PARITY_EN
    status[4]              = 1'b1;
`endif
    rdata = '0;
    if (sel && addr[3:2] == 2'd1) rdata = status;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (FIFOBITS+1)'(push) - (FIFOBITS+1)'(pop);
      if (wr_tx && full)          overflow <= 1'b1;
      else if (wr_st && wdata[3]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      shift  <= '0;
      bitn   <= '0;
      txd    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      shift  <= shift_nx;
      bitn   <= bitn_nx;
      txd    <= txd_nx;
`ifdef MMIO_UART_TX_PARITY_EN
      parity <= parity_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shift_nx  = shift;
    bitn_nx   = bitn;
    pop       = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
    parity_nx = parity;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nx  = head;
          cnt_nx    = RELOAD;
          state_nx  = S_START;
`ifdef MMIO_UART_TX_PARITY_EN
          parity_nx = ^head;
`endif
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          bitn_nx  = '0;
          state_nx = S_DATA;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          shift_nx = shift >> 1;
          if (bitn == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end else begin
            bitn_nx = bitn + 1'b1;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          cnt_nx   = RELOAD;
          state_nx = S_STOP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (cnt == '0) begin
          if (!empty) begin
            pop       = 1'b1;
            shift_nx  = head;
            cnt_nx    = RELOAD;
            state_nx  = S_START;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_nx = ^head;
`endif
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    txd_nx = 1'b1;
    case (state)
      S_START:  txd_nx = 1'b0;
      S_DATA:   txd_nx = shift[0];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: txd_nx = parity;
`endif
      default:  txd_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: decode table, hand-written frame sequences, and randomized traffic
// checked against a queue/timer reference model plus a bench-side serial receiver.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam int unsigned WIDTH    = 32;
  localparam logic [31:0] BASE     = 32'hFFFF_FF00;
  localparam int unsigned CLKDIV   = 4;
  localparam int unsigned FIFOBITS = 3;
  localparam int unsigned DEPTH    = 8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
  localparam logic [31:0] PB    = 32'h10;
`else
  localparam int unsigned NBITS = 10;
  localparam logic [31:0] PB    = 32'h0;
`endif
  localparam int unsigned FRAME = NBITS * CLKDIV;

  logic        clk = 1'b0, rst = 1'b1, memwrite = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        sel, txd;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  mmio_uart_tx #(.WIDTH(WIDTH), .BASE(BASE), .CLKDIV(CLKDIV), .FIFOBITS(FIFOBITS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .memwrite(memwrite),
    .sel(sel), .rdata(rdata), .txd(txd)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky overflow, and a frame timer that is nonzero while sending.
  byte unsigned m_q[$];
  byte unsigned exp_rx[$];
  bit           m_ovf = 1'b0;
  int           m_timer = 0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = PB;
    s[11:8] = 4'(m_q.size());
    s[3]    = m_ovf;
    s[2]    = (m_timer != 0);
    s[1]    = (m_q.size() == 0);
    s[0]    = (m_q.size() == DEPTH);
    return s;
  endfunction

  always @(posedge clk) begin
    bit hit, was_full, do_pop;
    if (rst) begin
      m_q.delete();
      exp_rx.delete();
      m_ovf   = 1'b0;
      m_timer = 0;
    end else begin
      hit      = (addr[31:4] == BASE[31:4]);
      was_full = (m_q.size() == DEPTH);
      do_pop   = 1'b0;
      if (m_timer == 0) do_pop = (m_q.size() != 0);
      else begin
        m_timer--;
        if (m_timer == 0 && m_q.size() != 0) do_pop = 1'b1;
      end
      if (do_pop) begin
        exp_rx.push_back(m_q.pop_front());
        m_timer = FRAME;
      end
      if (hit && memwrite && addr[3:2] == 2'd0) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back(wdata[7:0]);
      end
      if (hit && memwrite && addr[3:2] == 2'd1 && wdata[3]) m_ovf = 1'b0;
    end
  end

  // Serial receiver: samples mid-bit and matches every frame against the bytes the model popped.
  int          rx_cnt = -1;
  logic [7:0]  rx_byte = '0;
  logic        rx_par = 1'b0;
  always @(negedge clk) begin
    int k;
    if (rst) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (txd === 1'b0) rx_cnt = 0;
    end else rx_cnt++;
    if (!rst && rx_cnt >= 0 && (rx_cnt % CLKDIV) == CLKDIV/2) begin
      k = rx_cnt / CLKDIV;
      if (k == 0) check("rx_start", txd, 1'b0);
      else if (k <= 8) rx_byte[k-1] = txd;
`ifdef MMIO_UART_TX_PARITY_EN
      else if (k == 9) rx_par = txd;
`endif
      else begin
        check("rx_stop", txd, 1'b1);
`ifdef MMIO_UART_TX_PARITY_EN
        check("rx_parity", rx_par, ^rx_byte);
`endif
        if (exp_rx.size() == 0) check("rx_unexpected_frame", {24'h0, rx_byte}, 32'hFFFF_FFFF);
        else check("rx_byte", rx_byte, exp_rx.pop_front());
        rx_cnt = -1;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; memwrite = 1'b0;
    #1 d = rdata;
  endtask

  bit wave_q[$];
  task automatic add_frame(input logic [7:0] b);
    bit v;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = b[k-1];
      else if (k == 9 && NBITS == 11) v = ^b;
      else v = 1'b1;
      repeat (CLKDIV) wave_q.push_back(v);
    end
  endtask

  task automatic run_wave(input string nm);
    while (wave_q.size() != 0) begin
      @(posedge clk); #1;
      check(nm, txd, wave_q.pop_front());
    end
  endtask

  task automatic wait_idle(input int bound);
    logic [31:0] s;
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(posedge clk); #1;
      rd(BASE + 4, s);
      if (s[2] == 1'b0 && s[1] == 1'b1) done = 1'b1;
    end
    check("drain_timeout", done, 1'b1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        esel;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, a, exp_rd;
    int lows, r, rate;
    bit hit;

    tbl[0]  = '{BASE + 32'h0,  32'h0,  1'b0, 1'b1, 32'h0};
    tbl[1]  = '{BASE + 32'h4,  32'h0,  1'b0, 1'b1, 32'h2 | PB};
    tbl[2]  = '{BASE + 32'h8,  32'h0,  1'b0, 1'b1, 32'h0};
    tbl[3]  = '{BASE + 32'hC,  32'h0,  1'b0, 1'b1, 32'h0};
    tbl[4]  = '{BASE + 32'h10, 32'h55, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{BASE - 32'h4,  32'hAA, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{BASE + 32'h4,  32'h8,  1'b1, 1'b1, 32'h2 | PB};
    tbl[7]  = '{BASE + 32'h8,  32'h77, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{32'h0,         32'h12, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{BASE + 32'h7,  32'h0,  1'b0, 1'b1, 32'h2 | PB};
    tbl[10] = '{32'h7FFF_FF00, 32'h33, 1'b1, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    rd(BASE + 4, s);
    check("reset_status", s, 32'h2 | PB);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      addr = tbl[i].a; wdata = tbl[i].d; memwrite = tbl[i].we;
      #1;
      check($sformatf("tbl%0d_sel", i), sel, tbl[i].esel);
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].erd);
    end
    @(negedge clk) memwrite = 1'b0; addr = '0;
    @(posedge clk); #1;
    rd(BASE + 4, s);
    check("tbl_fifo_unchanged", s, 32'h2 | PB);
    check("tbl_txd_idle", txd, 1'b1);

    // Single frame of 8'hA5.
    wr(BASE, 32'hA5);
    rd(BASE + 4, s);
    check("a5_status_queued", s, 32'h100 | PB);
    @(posedge clk); #1;
    check("a5_txd_before_start", txd, 1'b1);
    add_frame(8'hA5);
    run_wave("a5_txd");
    rd(BASE + 4, s);
    check("a5_idle_after_frame", s, 32'h2 | PB);

    // Back-to-back frames with no idle gap.
    wr(BASE, 32'h00);
    wr(BASE, 32'hFF);
    add_frame(8'h00);
    add_frame(8'hFF);
    run_wave("b2b_txd");
    rd(BASE + 4, s);
    check("b2b_idle", s, 32'h2 | PB);

    // 8'h07: odd number of ones, so the parity bit (when present) is 1.
    wr(BASE, 32'h07);
    @(posedge clk); #1;
    add_frame(8'h07);
    run_wave("f07_txd");

    // Fill: one byte in the shifter, eight queued, then overflow and clear.
    for (int i = 0; i < 9; i++) wr(BASE, 32'(i * 17 + 1));
    rd(BASE + 4, s);
    check("fifo_full", s, 32'h805 | PB);
    wr(BASE, 32'hEE);
    rd(BASE + 4, s);
    check("fifo_overflow", s, 32'h80D | PB);
    wr(BASE + 4, 32'h8);
    rd(BASE + 4, s);
    check("overflow_clear", s, 32'h805 | PB);
    wait_idle(12 * FRAME);

    // Reset while the third byte (all zeros) is in its data bits.
    wr(BASE, 32'h31);
    wr(BASE, 32'h32);
    wr(BASE, 32'h00);
    repeat (2 * FRAME + 2 * CLKDIV) @(posedge clk);
    #1;
    check("pre_reset_txd_low", txd, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_txd", txd, 1'b1);
    rd(BASE + 4, s);
    check("reset_mid_status", s, 32'h2 | PB);
    @(negedge clk) rst = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    check("no_frames_after_reset", lows, 0);

    // Randomized traffic: a congested phase then a sparse one.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      rate = (i < 400) ? 40 : 3;
      memwrite = 1'b0;
      wdata = $urandom;
      if (r < rate) begin
        addr = BASE | ($urandom & 32'h3); memwrite = 1'b1;
      end else if (r < rate + 5) begin
        addr = BASE | 32'h4 | ($urandom & 32'h3); memwrite = 1'b1;
      end else if (r < rate + 10) begin
        a = $urandom;
        if (a[31:4] == BASE[31:4]) a = a ^ 32'h100;
        addr = a; memwrite = 1'b1;
      end else if (r < rate + 13) begin
        addr = BASE | 32'($urandom_range(2, 3) << 2); memwrite = 1'b1;
      end else begin
        addr = BASE | 32'h4;
      end
      #1;
      hit = (addr[31:4] == BASE[31:4]);
      exp_rd = (hit && addr[3:2] == 2'd1) ? m_status() : 32'h0;
      check("rnd_sel", sel, hit);
      check("rnd_rdata", rdata, exp_rd);
    end
    @(negedge clk) memwrite = 1'b0; addr = '0;
    wait_idle((DEPTH + 2) * FRAME);
    repeat (2) @(posedge clk);
    #1;
    check("rnd_all_frames_received", exp_rx.size(), 0);
    check("rnd_model_empty", m_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the pipelined core's data-memory port, downstream of the M stage. Decodes the core's data address, buffers written bytes in a FIFO, and serializes them as 8N1 frames on `txd`. Read data is combinational so the core's W-stage register captures it in the same cycle as dmem data. Top level muxes `rdata` over dmem read data when `sel` is high, and gates dmem write-enable with `~sel`.

## Interface
- `WIDTH`, 32, data/address width
- `BASE`, 32'hFFFF_FF00, base byte address; low 4 bits ignored
- `CLKDIV`, 434, clock cycles per serial bit (≥2)
- `FIFOBITS`, 3, log2 FIFO depth (8 entries)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `addr`  in  WIDTH  core `aluout` (M stage byte address)
- `wdata`  in  WIDTH  core `writedata`
- `memwrite`  in  1  core `memwrite`
- `sel`  out  1  address hit, combinational
- `rdata`  out  WIDTH  read data, combinational
- `txd`  out  1  serial output, registered, idle high

## Operation
- Hit: `sel = (addr[WIDTH-1:4] == BASE[WIDTH-1:4])`; register = `addr[3:2]`.
- Reg 0 TXDATA: write with `sel & memwrite` pushes `wdata[7:0]`; reads 0.
- Reg 1 STATUS: read {count[FIFOBITS:0] at bits [8+FIFOBITS:8], bit3 overflow, bit2 busy, bit1 empty, bit0 full}, other bits 0. Write with `wdata[3]=1` clears overflow; other bits ignored.
- Regs 2,3: read 0, writes ignored. `rdata` = 0 when `sel` low.
- Push when full: byte dropped, overflow set (sticky). Full is evaluated on pre-pop state: push while full is dropped even if a pop occurs the same cycle.
- FIFO: circular, pointers wrap at 2^FIFOBITS, count 0..2^FIFOBITS; simultaneous push+pop with non-full FIFO keeps count unchanged.
- FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - IDLE: if FIFO non-empty, pop head into shift register, load baud counter, go START.
  - Each of START/DATA bit/STOP lasts exactly CLKDIV cycles (counter CLKDIV-1 down to 0).
  - DATA: shift after each bit; after bit 7 go STOP.
  - STOP end: if FIFO non-empty, pop and go START directly (no idle gap); else IDLE.
- `txd`: 1 in IDLE/STOP, 0 in START, shift[0] in DATA. busy = state != IDLE.

## Timing
- Reset: FIFO empty, pointers 0, overflow 0, state IDLE, `txd`=1, counter 0; `sel`/`rdata` follow inputs.
- Push at edge N: STATUS count/empty reflect it in cycle N+1 (combinational read of registered state).
- Push into empty FIFO in IDLE at edge N: pop at edge N+1, `txd` falls at N+2 (registered).
- Frame = 10·CLKDIV cycles; back-to-back frames contiguous.
- Reset mid-frame: `txd` returns to 1 next edge, queued bytes discarded.
- Write while `sel` low: no effect on block.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP, lasting CLKDIV cycles, `txd` = even parity (XOR of 8 data bits); frame = 11·CLKDIV. STATUS bit4 reads 1.
- Undefined: 8N1, 10·CLKDIV frame, STATUS bit4 reads 0.

## Test plan
- Reset, CLKDIV=4: `txd`=1, STATUS read = 32'h0000_0002 (empty).
- Write 8'hA5 to BASE+0: `txd` low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; busy 0 after 40 cycles post-start.
- Write 9 bytes with FIFO idle-blocked by first frame: 1 in shifter + 8 queued, STATUS full=1 count=8, 10th write sets overflow; write 32'h8 to BASE+4 clears it.
- Two bytes 8'h00, 8'hFF back-to-back: second start bit immediately after first stop, total 80 cycles, no idle gap.
- Assert `rst` mid-DATA of byte 3: `txd`=1 next cycle, STATUS = 32'h0000_0002, no further frames.
- Write to address BASE+16 with memwrite: `sel`=0, `rdata`=0, FIFO count unchanged; with PARITY_EN, 8'h07 frame has parity bit 1, length 44 cycles.
